// File: rtl/coil_pwm_generator_if.sv
// rtl/coil_pwm_generator_if.sv - command handshake bundle for the coil PWM generator
interface coil_pwm_generator_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_enable;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_period;
  logic [CNT_W-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_enable,
    output cmd_dir,
    output cmd_period,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_enable,
    input  cmd_dir,
    input  cmd_period,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/coil_pwm_generator.sv
// rtl/coil_pwm_generator.sv - single-coil PWM gate request generator with enforced dead time on reversal
module coil_pwm_generator #(
  parameter int CNT_W       = 16,
  parameter int DEAD_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  coil_pwm_generator_if.slave   cmd,
  output logic                  InVGSf,
  output logic                  InVGSr,
  output logic                  period_start,
  output logic                  dead_active,
  output logic                  cmd_err
);

  localparam int DW = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic [DW-1:0]    dead_q, dead_d;

  logic             pend_valid_q, pend_valid_d;
  logic             pend_enable_q, pend_enable_d;
  logic             pend_dir_q, pend_dir_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_duty_q, pend_duty_d;

  logic             fwd_q, fwd_d;
  logic             rev_q, rev_d;
  logic             ps_q, ps_d;
  logic             da_q, da_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic             apply;
  logic             cmd_fire;
  logic             cmd_bad;
  logic             wrap;
  logic             run_d;

  assign cmd_fire = cmd.cmd_valid && ready_q;
  assign cmd_bad  = cmd.cmd_enable &&
                    ((cmd.cmd_period == '0) || (cmd.cmd_duty > cmd.cmd_period));
  assign wrap     = (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    duty_d        = duty_q;
    dir_d         = dir_q;
    dead_d        = dead_q;
    pend_valid_d  = pend_valid_q;
    pend_enable_d = pend_enable_q;
    pend_dir_d    = pend_dir_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    err_d         = 1'b0;
    apply         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_valid_q) begin
          if (pend_enable_q) begin
            apply = 1'b1;
          end else begin
            pend_valid_d = 1'b0;
          end
        end
      end

      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            if (pend_enable_q && (pend_dir_q == dir_q)) begin
              apply = 1'b1;
            end else begin
              // A reversal stays pending through DEAD; a stop is consumed here.
              state_d = DEAD;
              dead_d  = {1'b0, duty_q} + DW'(DEAD_MARGIN);
              if (!pend_enable_q) begin
                pend_valid_d = 1'b0;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DEAD: begin
        cnt_d = '0;
        if (dead_q <= DW'(1)) begin
          dead_d = '0;
          if (pend_valid_q && pend_enable_q) begin
            apply = 1'b1;
          end else begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
          end
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply) begin
      state_d      = RUN;
      cnt_d        = '0;
      dir_d        = pend_dir_q;
      period_d     = pend_period_q;
      duty_d       = pend_duty_q;
      pend_valid_d = 1'b0;
    end

    // Capture only happens with the slot empty, so it never collides with apply.
    if (cmd_fire) begin
      if (cmd_bad) begin
        err_d = 1'b1;
      end else begin
        pend_valid_d  = 1'b1;
        pend_enable_d = cmd.cmd_enable;
        pend_dir_d    = cmd.cmd_dir;
        pend_period_d = cmd.cmd_period;
        pend_duty_d   = cmd.cmd_duty;
      end
    end
  end

  assign run_d   = (state_d == RUN);
  assign fwd_d   = run_d && dir_d && (cnt_d < duty_d);
  assign rev_d   = run_d && !dir_d && (cnt_d < duty_d);
  assign ps_d    = run_d && (cnt_d == '0);
  assign da_d    = (state_d == DEAD);
  assign ready_d = !pend_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_q      <= '0;
      duty_q        <= '0;
      dir_q         <= 1'b0;
      dead_q        <= '0;
      pend_valid_q  <= 1'b0;
      pend_enable_q <= 1'b0;
      pend_dir_q    <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      fwd_q         <= 1'b0;
      rev_q         <= 1'b0;
      ps_q          <= 1'b0;
      da_q          <= 1'b0;
      err_q         <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      dir_q         <= dir_d;
      dead_q        <= dead_d;
      pend_valid_q  <= pend_valid_d;
      pend_enable_q <= pend_enable_d;
      pend_dir_q    <= pend_dir_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      fwd_q         <= fwd_d;
      rev_q         <= rev_d;
      ps_q          <= ps_d;
      da_q          <= da_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
    end
  end

  assign InVGSf        = fwd_q;
  assign InVGSr        = rev_q;
  assign period_start  = ps_q;
  assign dead_active   = da_q;
  assign cmd_err       = err_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_coil_pwm_generator.sv
// tb/tb_coil_pwm_generator.sv - directed and random-stream bench for coil_pwm_generator
module tb_coil_pwm_generator;
  localparam int CNT_W = 16;
  localparam int DM    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coil_pwm_generator_if #(.CNT_W(CNT_W)) cif ();

  logic f, r, ps, da, err;

  coil_pwm_generator #(
    .CNT_W       (CNT_W),
    .DEAD_MARGIN (DM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cif.slave),
    .InVGSf       (f),
    .InVGSr       (r),
    .period_start (ps),
    .dead_active  (da),
    .cmd_err      (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_f = -1000;
  int last_r = -1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic d, input int p, input int du);
    cif.cmd_valid  = v;
    cif.cmd_enable = en;
    cif.cmd_dir    = d;
    cif.cmd_period = CNT_W'(p);
    cif.cmd_duty   = CNT_W'(du);
  endtask

  task automatic count(input int n, output int nf, output int nr, output int nps, output int nd);
    nf = 0; nr = 0; nps = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      nf  += int'(f);
      nr  += int'(r);
      nps += int'(ps);
      nd  += int'(da);
    end
  endtask

  task automatic dead_len(output int nd, output int nbad);
    nd = 0; nbad = 0;
    while (da === 1'b1 && nd < 200) begin
      nd++;
      if (f || r || ps) nbad++;
      step();
    end
  endtask

  // Gate safety monitor: never both high, and a reversal always leaves a gap.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_f = -1000;
      last_r = -1000;
    end else begin
      checks++;
      assert (!(f === 1'b1 && r === 1'b1)) else begin
        errors++;
        $error("FAIL both_high observed=1 expected=0 cycle=%0d", cyc);
      end
      if (r === 1'b1) begin
        checks++;
        assert (cyc - last_f > DM) else begin
          errors++;
          $error("FAIL rev_gap observed=%0d expected>%0d", cyc - last_f, DM);
        end
        last_r = cyc;
      end
      if (f === 1'b1) begin
        checks++;
        assert (cyc - last_r > DM) else begin
          errors++;
          $error("FAIL fwd_gap observed=%0d expected>%0d", cyc - last_r, DM);
        end
        last_f = cyc;
      end
    end
  end

  initial begin
    int nf, nr, nps, nd, nbad, p, du;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_f", f, 0);
    chk("rst_r", r, 0);
    chk("rst_ps", ps, 0);
    chk("rst_dead", da, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    rst = 1'b0;

    // forward p10 d4 from IDLE
    drive(1, 1, 1, 10, 4);
    step();
    chk("a_ready_pend", cif.cmd_ready, 0);
    chk("a_f_before", f, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("a_f_first", f, 1);
    chk("a_ps_first", ps, 1);
    chk("a_ready_free", cif.cmd_ready, 1);
    count(20, nf, nr, nps, nd);
    chk("a_nf", nf, 8);
    chk("a_nps", nps, 2);
    chk("a_nr", nr, 0);

    // same-direction change offered on the wrap cycle: applies one period later
    drive(1, 1, 1, 20, 15);
    step();
    chk("b_ready", cif.cmd_ready, 0);
    drive(0, 0, 0, 0, 0);
    count(10, nf, nr, nps, nd);
    chk("b_old_nf", nf, 4);
    chk("b_old_nps", nps, 1);
    step();
    chk("b_new_f", f, 1);
    chk("b_new_ps", ps, 1);
    count(20, nf, nr, nps, nd);
    chk("b_nf", nf, 15);
    chk("b_nps", nps, 1);
    chk("b_nd", nd, 0);
    chk("b_nr", nr, 0);

    // reversal: DEAD lasts 15 + 4 cycles
    drive(1, 1, 0, 10, 6);
    step();
    drive(0, 0, 0, 0, 0);
    count(20, nf, nr, nps, nd);
    chk("c_last_fwd_nf", nf, 15);
    step();
    chk("c_dead_on", da, 1);
    dead_len(nd, nbad);
    chk("c_dead_len", nd, 19);
    chk("c_dead_outputs", nbad, 0);
    chk("c_rev_r", r, 1);
    chk("c_rev_ps", ps, 1);
    count(10, nf, nr, nps, nd);
    chk("c_nr", nr, 6);
    chk("c_nf", nf, 0);

    // rejects: duty > period, period == 0
    drive(1, 1, 0, 8, 9);
    step();
    chk("d_err1", err, 1);
    chk("d_ready1", cif.cmd_ready, 1);
    chk("d_r", r, 1);
    drive(0, 0, 0, 0, 0);
    step();
    chk("d_err1_clr", err, 0);
    drive(1, 1, 0, 0, 0);
    step();
    chk("d_err2", err, 1);
    drive(0, 0, 0, 0, 0);
    step();
    chk("d_err2_clr", err, 0);
    chk("d_r_cnt3", r, 1);
    for (int i = 0; i < 6; i++) step();
    step();
    chk("d_wrap_r", r, 1);
    chk("d_wrap_ps", ps, 1);
    chk("d_wrap_dead", da, 0);

    // second offer while pending is held off; duty == period
    drive(1, 1, 0, 4, 4);
    step();
    chk("e_ready0", cif.cmd_ready, 0);
    drive(1, 1, 0, 4, 0);
    for (int i = 0; i < 8; i++) step();
    chk("e_ready_held", cif.cmd_ready, 0);
    step();
    chk("e_ready_back", cif.cmd_ready, 1);
    drive(0, 0, 0, 0, 0);
    count(8, nf, nr, nps, nd);
    chk("e_full_nr", nr, 8);
    chk("e_nps", nps, 2);

    // duty == 0 keeps gates low while counting
    drive(1, 1, 0, 4, 0);
    step();
    drive(0, 0, 0, 0, 0);
    count(4, nf, nr, nps, nd);
    chk("f_old_nr", nr, 4);
    step();
    count(8, nf, nr, nps, nd);
    chk("f_zero_nr", nr, 0);
    chk("f_zero_nf", nf, 0);
    chk("f_zero_nps", nps, 2);

    // stop: DEAD for 0 + 4 cycles, then IDLE
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    step();
    dead_len(nd, nbad);
    chk("g_dead_len", nd, 4);
    count(4, nf, nr, nps, nd);
    chk("g_idle_f", nf + nr + nps + nd, 0);
    chk("g_idle_ready", cif.cmd_ready, 1);

    // command accepted during DEAD does not shorten it
    drive(1, 1, 1, 6, 3);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("h_f", f, 1);
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    step();
    chk("h_dead", da, 1);
    chk("h_dead_ready", cif.cmd_ready, 1);
    drive(1, 1, 0, 5, 2);
    step();
    chk("h_dead_pend", cif.cmd_ready, 0);
    drive(0, 0, 0, 0, 0);
    dead_len(nd, nbad);
    chk("h_dead_len", nd + 1, 7);
    chk("h_r", r, 1);
    chk("h_ps", ps, 1);

    // reset mid-DEAD discards pending reversal
    drive(1, 1, 1, 5, 5);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("i_dead", da, 1);
    chk("i_ready0", cif.cmd_ready, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("i_rst_dead", da, 0);
    chk("i_rst_ready", cif.cmd_ready, 1);
    step();
    count(8, nf, nr, nps, nd);
    chk("i_after_rst", nf + nr + nps + nd, 0);

    // random command stream under the safety monitor
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        p  = int'($urandom_range(1, 12));
        du = int'($urandom_range(0, 13));
        drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, p, du);
      end else begin
        cif.cmd_valid = 1'b0;
      end
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/coil_pwm_generator.md
COIL_PWM_GENERATOR -- requirements
Module: coil_pwm_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period/duty fields and counters.
REQ-002 SHALL have parameter DEAD_MARGIN, default 4, extra dead cycles added after last on-time before a direction change.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command slot free.
REQ-007 SHALL have port cmd_enable  input  1  1 = drive coil, 0 = stop.
REQ-008 SHALL have port cmd_dir  input  1  1 = forward, 0 = reverse.
REQ-009 SHALL have port cmd_period  input  CNT_W  PWM period in clk cycles.
REQ-010 SHALL have port cmd_duty  input  CNT_W  on-cycles per period.
REQ-011 SHALL have port InVGSf  output  1  forward gate request to H-bridge controller.
REQ-012 SHALL have port InVGSr  output  1  reverse gate request to H-bridge controller.
REQ-013 SHALL have port period_start  output  1  one-cycle pulse when period counter is 0 in RUN.
REQ-014 SHALL have port dead_active  output  1  high while in DEAD state.
REQ-015 SHALL have port cmd_err  output  1  one-cycle pulse on rejected command.

Function
REQ-016 SHALL accept a command on the cycle cmd_valid && cmd_ready, capturing all cmd_* fields into a single pending register.
REQ-017 SHALL reject (not capture, pulse cmd_err next cycle) a command with cmd_enable=1 and (cmd_period==0 or cmd_duty>cmd_period); cmd_ready stays high.
REQ-018 SHALL drive cmd_ready = !pending_valid; pending cleared on the cycle it is applied.
REQ-019 SHALL implement states IDLE, RUN, DEAD; all outputs registered.
REQ-020 IDLE: outputs low; pending enable command applied immediately -> RUN with counter 0, first on-cycle output one clock after apply; pending disable command discarded.
REQ-021 RUN: counter counts 0..period-1 and wraps; active output (InVGSf if dir=1, else InVGSr) high while counter < duty; other output low.
REQ-022 RUN: pending command examined only at wrap (counter==period-1); same direction and enabled -> new period/duty take effect from counter 0 with no gap.
REQ-023 RUN at wrap: pending with opposite direction or cmd_enable=0 -> DEAD, dead counter loaded with active duty + DEAD_MARGIN (CNT_W+1 bits, no overflow).
REQ-024 DEAD: both outputs low; dead counter decrements to 0; then pending enable command (any direction) -> RUN at counter 0, else -> IDLE.
REQ-025 Commands accepted during DEAD SHALL be held pending and never shorten DEAD.
REQ-026 duty=0 SHALL keep both outputs low while RUN continues counting; duty=period SHALL hold active output high the full period.
REQ-027 InVGSf and InVGSr SHALL never be high in the same cycle, including across state changes.
REQ-028 Direction reversal SHALL always pass through DEAD; no cycle with forward high SHALL be followed within duty+DEAD_MARGIN cycles by reverse high, and vice versa.
REQ-029 cmd_valid and an internal wrap on the same cycle: command captured this cycle, applied at the next wrap, not this one.

Reset
REQ-030 On rst high at a clock edge: state IDLE, InVGSf=0, InVGSr=0, period_start=0, dead_active=0, cmd_err=0, pending cleared, cmd_ready=1, counters 0.
REQ-031 rst asserted mid-RUN or mid-DEAD SHALL drop outputs low on the next edge and discard pending command; no dead period enforced afterwards.

Verification
REQ-032 IDLE, cmd fwd period=10 duty=4 -> InVGSf high 4 of every 10 cycles, period_start every 10 cycles, InVGSr=0.
REQ-033 RUN fwd duty=4, cmd rev period=10 duty=6 -> at wrap DEAD for 8 cycles (4+4), dead_active high, then InVGSr high 6 of 10.
REQ-034 RUN fwd, cmd fwd period=20 duty=15 -> switch at wrap with no low gap beyond normal off-time, no DEAD.
REQ-035 cmd period=8 duty=9 -> cmd_err pulse, outputs unchanged; cmd period=0 -> cmd_err.
REQ-036 Second cmd offered while pending -> cmd_ready=0, held until applied; rst mid-DEAD -> outputs 0, cmd_ready=1 next cycle.
REQ-037 Random command stream, 10k cycles -> assertion: never both outputs high; reversal gap >= duty+DEAD_MARGIN.
